// File: rtl/unidade_pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | unidade_pc_pkg: opcodes and sequencing-state encoding for unidade_pc       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package unidade_pc_pkg;

  localparam logic [4:0] c_OP_HLT = 5'b00001;
  localparam logic [4:0] c_OP_IN  = 5'b00010;
  localparam logic [4:0] c_OP_ADD = 5'b01011;

  // 2'd3 is unused; the top treats it as a fault and parks in PARADO.
  typedef enum logic [1:0] {
    EXEC      = 2'd0,
    ESPERA_IN = 2'd1,
    PARADO    = 2'd2
  } estado_t;

endpackage : unidade_pc_pkg
`default_nettype wire

// File: rtl/unidade_pc_detector_borda.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | detector_borda: 2-flop synchronizer + history flop, rising-edge pulse     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic i_sinal,
  output logic o_evento
);

  logic r_sinc1;
  logic r_sinc2;
  logic r_hist;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sinc1 <= 1'b0;
      r_sinc2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sinc1 <= i_sinal;
      r_sinc2 <= r_sinc1;
      r_hist  <= r_sinc2;
    end
  end

  assign o_evento = r_sinc2 & ~r_hist;

endmodule : detector_borda
`default_nettype wire

// File: rtl/unidade_pc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | unidade_pc: PC, stall-on-IN sequencing, commit enable, retire counter     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module unidade_pc
  import unidade_pc_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter int         INIT_PC = 0,
  parameter logic [4:0] OP_IN   = c_OP_IN,
  parameter logic [4:0] OP_HLT  = c_OP_HLT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        opcode,
  input  logic              halt,
  input  logic              jump,
  input  logic [31:0]       jumpE,
  input  logic              confirma,
  output logic [ADDR_W-1:0] pc,
  output logic              habilita,
  output logic              esperando,
  output logic              parado,
  output logic              erro,
  output logic [31:0]       contagem
);

  // A misconfigured IN code equal to HLT must never turn a halt opcode into a stall.
  localparam logic c_IN_VALIDO = (OP_IN != OP_HLT);

  estado_t           r_estado;
  estado_t           w_estado_prox;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_prox;
  logic              r_erro;
  logic              w_erro_set;
  logic [31:0]       r_contagem;
  logic              w_evento;
  logic              w_habilita;
  logic              w_esperando;
  logic              w_parado;
  logic              w_alvo_fora;

  detector_borda u_detector_borda (
    .clock    (clock),
    .reset    (reset),
    .i_sinal  (confirma),
    .o_evento (w_evento)
  );

  assign w_alvo_fora = |(jumpE >> ADDR_W);

  always_comb begin
    w_estado_prox = r_estado;
    w_pc_prox     = r_pc;
    w_habilita    = 1'b0;
    w_esperando   = 1'b0;
    w_parado      = 1'b0;
    w_erro_set    = 1'b0;
    case (r_estado)
      EXEC: begin
        if (halt) begin
          w_estado_prox = PARADO;
        end else if (c_IN_VALIDO && (opcode == OP_IN)) begin
          w_estado_prox = ESPERA_IN;
        end else if (jump && !w_alvo_fora) begin
          w_pc_prox  = jumpE[ADDR_W-1:0];
          w_habilita = 1'b1;
        end else if (jump) begin
          w_estado_prox = PARADO;
          w_erro_set    = 1'b1;
        end else begin
          w_pc_prox  = r_pc + 1'b1;
          w_habilita = 1'b1;
        end
      end
      ESPERA_IN: begin
        w_esperando = 1'b1;
        if (w_evento) begin
          w_pc_prox     = r_pc + 1'b1;
          w_habilita    = 1'b1;
          w_estado_prox = EXEC;
        end
      end
      PARADO: begin
        w_parado = 1'b1;
      end
      default: begin
        w_parado      = 1'b1;
        w_estado_prox = PARADO;
        w_erro_set    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= EXEC;
      r_pc       <= ADDR_W'(INIT_PC);
      r_erro     <= 1'b0;
      r_contagem <= 32'd0;
    end else begin
      r_estado <= w_estado_prox;
      r_pc     <= w_pc_prox;
      if (w_erro_set) begin
        r_erro <= 1'b1;
      end
      if (w_habilita && (r_contagem != 32'hFFFF_FFFF)) begin
        r_contagem <= r_contagem + 32'd1;
      end
    end
  end

  assign pc        = r_pc;
  assign habilita  = w_habilita;
  assign esperando = w_esperando;
  assign parado    = w_parado;
  assign erro      = r_erro;
  assign contagem  = r_contagem;

endmodule : unidade_pc
`default_nettype wire

// File: doc/unidade_pc.md
Name: unidade_pc

Overview:
- Program-counter and sequencing stage that sits directly downstream of the control unit. It consumes the opcode and the halt, jump and jumpE outputs, holds the PC that addresses instruction memory, and stalls on IN until the operator confirm button is pressed.
- It produces a commit enable. Register-file and data-memory writes must be ANDed with this enable, so a stalled or halted instruction never writes.
- It also counts retired instructions.

Parameters:
- ADDR_W, 10, width of PC / instruction-memory address.
- INIT_PC, 0, PC value loaded on reset.
- OP_IN, 5'b00010, opcode that stalls for operator input.
- OP_HLT, 5'b00001, opcode reported on halt (informational; halting is driven by the halt input).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  5  current instruction opcode.
- halt  in  1  from control unit.
- jump  in  1  from control unit; take branch.
- jumpE  in  32  branch target from control unit.
- confirma  in  1  raw asynchronous operator button, active-high.
- pc  out  ADDR_W  instruction-memory address.
- habilita  out  1  commit enable for the current instruction.
- esperando  out  1  high while stalled on IN.
- parado  out  1  high once halted.
- erro  out  1  sticky; jump target out of range.
- contagem  out  32  retired-instruction count, saturating.

Behaviour:
- Reset (reset==0 at a rising clock edge):
  - pc=INIT_PC, state=EXEC, erro=0, contagem=0.
  - Synchronizer flops and the edge-history flop are cleared to 0.
  - Reset takes effect from any state, including ESPERA_IN and PARADO.
- confirma path:
  - Two-flop synchronizer, then a history flop.
  - evento = sync2 & ~hist, a one-cycle pulse.
  - Latency is 2 clocks from confirma rising to evento high.
  - A held button produces exactly one evento.
- State EXEC:
  - Priority halt > IN > jump > sequential.
  - If halt: go to PARADO; pc holds; habilita=0.
  - Else if opcode==OP_IN: go to ESPERA_IN; pc holds; habilita=0.
  - Else if jump and jumpE[31:ADDR_W]==0: pc=jumpE[ADDR_W-1:0]; habilita=1.
  - Else if jump and any jumpE[31:ADDR_W] bit set: go to PARADO; erro=1; pc holds; habilita=0.
  - Else: pc=pc+1 modulo 2^ADDR_W (all-ones wraps to 0, no flag); habilita=1.
  - An evento arriving in EXEC is discarded.
- State ESPERA_IN:
  - esperando=1.
  - habilita=1 combinationally only in the cycle evento==1. That cycle: pc=pc+1 (wrapping) and state returns to EXEC.
  - Otherwise habilita=0 and pc holds.
  - halt and jump are ignored in this state.
- State PARADO:
  - parado=1, habilita=0, pc frozen.
  - Exits only via reset.
- habilita, esperando and parado are combinational from state, opcode, halt, jump, jumpE and evento. pc, erro and contagem are registered.
- contagem: +1 at each clock edge where habilita==1. Holds at 32'hFFFF_FFFF.
- Latency: a sequential instruction or taken jump updates pc in one clock.

Decomposition:
- Shared package (alongside the control-unit opcode constants):
  - opcode constants OP_IN, OP_HLT.
  - state encoding EXEC=2'd0, ESPERA_IN=2'd1, PARADO=2'd2.
  - 2'd3 is illegal and recovers to PARADO with erro=1.
- One sub-module: detector_borda (two-flop synchronizer, history flop, rising-edge pulse), with clock/reset as above.

Test Plan:
- Reset release with opcode=ADD (5'b01011), no jump, 5 clocks -> pc 0,1,2,3,4,5; habilita=1 each cycle; contagem=5.
- At pc=7, jump=1, jumpE=32'd300 -> next pc=300, contagem +1. Then jumpE=32'd1024 with ADDR_W=10 -> parado=1, erro=1, pc stays 300, habilita=0 thereafter.
- At pc=3, opcode=OP_IN -> esperando=1 and pc holds 3 for 20 clocks. Pulse confirma held 10 cycles -> exactly one habilita pulse 2 clocks after the rise; pc=4; esperando=0. A second confirma press while in EXEC -> no effect.
- At pc=1023, sequential opcode -> pc=0, erro=0.
- At pc=9, halt=1 together with jump=1 -> parado=1 and pc=9; jump ignored. After reset low for 1 clock -> pc=0, parado=0, contagem=0.
- In ESPERA_IN, reset low -> EXEC, pc=0, esperando=0. A confirma edge in flight at reset -> no habilita after reset.
